// File: rtl/mbist_pkg.sv
// Shared MBIST types: controller state encoding and the fail-log entry layout.
package mbist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mbist_state_e;

  localparam int ERR_W      = 16;
  localparam int LOG_ADDR_W = 10;
  localparam int LOG_DATA_W = 8;

  typedef struct packed {
    logic [LOG_ADDR_W-1:0] addr;
    logic [LOG_DATA_W-1:0] syndrome;
  } log_entry_t;
endpackage

// File: rtl/mbist_fail_fifo.sv
// Fail-log FIFO with first-word fall-through; a pop frees a slot for a same-cycle push.
module mbist_fail_fifo
  import mbist_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  log_entry_t din,
  output log_entry_t dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  log_entry_t     mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mbist_response_analyzer.sv
// MBIST read-side checker: aligns address/expected data to the memory latency,
// compares, counts and logs failures, and reports pass/fail after the march ends.
module mbist_response_analyzer
  import mbist_pkg::*;
#(
  parameter int ADDR_W    = LOG_ADDR_W,
  parameter int DATA_W    = LOG_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int LOG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_syndrome,
  input  logic              log_pop,
  output logic              log_overflow
);
  mbist_state_e state, state_nxt;
  logic [2:0]   drain_cnt;

  logic [RD_LAT:1]             vld_pipe;
  logic [RD_LAT:1][ADDR_W-1:0] addr_pipe;
  logic [RD_LAT:1][DATA_W-1:0] exp_pipe;

  logic [DATA_W-1:0] syn;
  logic              rd_acc, mism, log_push, log_empty, log_full;
  log_entry_t        push_entry, head_entry;

  assign rd_acc = rd_en && (state == RUN);
  assign syn    = rd_data ^ exp_pipe[RD_LAT];
  assign mism   = vld_pipe[RD_LAT] && (syn != '0);
  // A compare landing on the start cycle belongs to the aborted run.
  assign log_push = mism && !start;

  always_ff @(posedge clk) begin
    if (rst || start) vld_pipe <= '0;
    else begin
      for (int i = RD_LAT; i > 1; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[1] <= rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = RD_LAT; i > 1; i--) begin
      addr_pipe[i] <= addr_pipe[i-1];
      exp_pipe[i]  <= exp_pipe[i-1];
    end
    addr_pipe[1] <= rd_addr;
    exp_pipe[1]  <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (finish) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
      default: state_nxt = state;
    endcase
    if (start) state_nxt = RUN;
  end

  // DRAIN lasts RD_LAT cycles so the read issued with finish is compared.
  always_ff @(posedge clk) begin
    if (rst) drain_cnt <= '0;
    else if (state == RUN && finish && !start) drain_cnt <= 3'(RD_LAT - 1);
    else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || start) err_cnt <= '0;
    else if (mism && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || start) log_overflow <= 1'b0;
    else if (mism && log_full && !(log_pop && !log_empty)) log_overflow <= 1'b1;
  end

  always_comb begin
    push_entry          = '0;
    push_entry.addr     = LOG_ADDR_W'(addr_pipe[RD_LAT]);
    push_entry.syndrome = LOG_DATA_W'(syn);
  end

  mbist_fail_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (log_push),
    .pop   (log_pop),
    .din   (push_entry),
    .dout  (head_entry),
    .empty (log_empty),
    .full  (log_full)
  );

  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == DONE);
  assign pass         = done && (err_cnt == '0);
  assign log_valid    = !log_empty;
  assign log_addr     = log_empty ? '0 : ADDR_W'(head_entry.addr);
  assign log_syndrome = log_empty ? '0 : DATA_W'(head_entry.syndrome);
endmodule

// File: tb/tb_mbist_response_analyzer.sv
// Directed bench: three analyzers (RD_LAT 1, 2, 4) share stimulus; each sees its own delayed memory.
module tb_mbist_response_analyzer;
  logic        clk = 1'b0;
  logic        rst, start, finish, rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  exp_data, ret;
  logic [7:0]  dl [4];
  logic [2:0]  busy, done, pass, log_valid, log_overflow, log_pop;
  logic [15:0] err_cnt [3];
  logic [9:0]  log_addr [3];
  logic [7:0]  log_syn [3];
  logic [7:0]  rd_data [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: ret is what the memory returns for the read issued this cycle.
  always @(posedge clk) begin
    dl[0] <= ret;
    dl[1] <= dl[0];
    dl[2] <= dl[1];
    dl[3] <= dl[2];
  end

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    assign rd_data[g] = dl[L-1];
    mbist_response_analyzer #(.ADDR_W(10), .DATA_W(8), .RD_LAT(L), .LOG_DEPTH(4)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .finish       (finish),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .exp_data     (exp_data),
      .rd_data      (rd_data[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .pass         (pass[g]),
      .err_cnt      (err_cnt[g]),
      .log_valid    (log_valid[g]),
      .log_addr     (log_addr[g]),
      .log_syndrome (log_syn[g]),
      .log_pop      (log_pop[g]),
      .log_overflow (log_overflow[g])
    );
  end

  typedef struct {
    logic [9:0]  addr;
    logic [7:0]  exp;
    logic [7:0]  ret;
    logic [15:0] err;
    logic [7:0]  syn;
    logic        pass;
  } vec_t;

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lat%0d: got %0h want %0h", name, lat_of(i), act, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".busy"}, i, busy[i], 0);
      chk({tag, ".done"}, i, done[i], 0);
      chk({tag, ".pass"}, i, pass[i], 0);
      chk({tag, ".err"}, i, err_cnt[i], 0);
      chk({tag, ".logv"}, i, log_valid[i], 0);
      chk({tag, ".log_addr"}, i, log_addr[i], 0);
      chk({tag, ".log_syn"}, i, log_syn[i], 0);
      chk({tag, ".ovf"}, i, log_overflow[i], 0);
    end
  endtask

  task automatic do_start(string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".start_busy"}, i, busy[i], 1);
      chk({tag, ".start_err"}, i, err_cnt[i], 0);
      chk({tag, ".start_logv"}, i, log_valid[i], 0);
    end
  endtask

  task automatic rd(logic [9:0] a, logic [7:0] e, logic [7:0] r, logic fin);
    rd_en = 1'b1; rd_addr = a; exp_data = e; ret = r; finish = fin;
  endtask

  // Called with finish driven for the current cycle; done must rise RD_LAT+1 cycles later.
  task automatic wait_done(string tag);
    int first [3];
    first = '{0, 0, 0};
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 1) begin rd_en = 1'b0; finish = 1'b0; end
      for (int i = 0; i < 3; i++) if (done[i] && first[i] == 0) first[i] = n;
    end
    for (int i = 0; i < 3; i++) chk({tag, ".done_lat"}, i, first[i], lat_of(i) + 1);
  endtask

  initial begin
    vec_t vecs [4];
    vecs[0] = '{addr: 10'h07A, exp: 8'h55, ret: 8'h57, err: 16'd1, syn: 8'h02, pass: 1'b0};
    vecs[1] = '{addr: 10'h3FF, exp: 8'h00, ret: 8'h80, err: 16'd1, syn: 8'h80, pass: 1'b0};
    vecs[2] = '{addr: 10'h000, exp: 8'hFF, ret: 8'hFF, err: 16'd0, syn: 8'h00, pass: 1'b1};
    vecs[3] = '{addr: 10'h155, exp: 8'hAA, ret: 8'h55, err: 16'd1, syn: 8'hFF, pass: 1'b0};

    rst = 1'b1; start = 1'b0; finish = 1'b0; rd_en = 1'b0;
    rd_addr = '0; exp_data = '0; ret = '0; log_pop = '0;
    step(3);
    chk_zero("reset");
    rst = 1'b0;
    step();

    // All-match march over the full address space.
    do_start("allmatch");
    for (int a = 0; a < 1023; a++) begin
      rd(10'(a), 8'hA5, 8'hA5, 1'b0);
      step();
    end
    rd(10'h3FF, 8'hA5, 8'hA5, 1'b1);
    wait_done("allmatch");
    for (int i = 0; i < 3; i++) begin
      chk("allmatch.pass", i, pass[i], 1);
      chk("allmatch.err", i, err_cnt[i], 0);
      chk("allmatch.logv", i, log_valid[i], 0);
    end

    // Single-read table: the faulty word sits between two matching neighbours.
    for (int v = 0; v < 4; v++) begin
      do_start("vec");
      rd(~vecs[v].addr, 8'h33, 8'h33, 1'b0); step();
      rd(vecs[v].addr, vecs[v].exp, vecs[v].ret, 1'b0); step();
      rd(vecs[v].addr + 10'd1, 8'h33, 8'h33, 1'b1);
      wait_done($sformatf("vec%0d", v));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("vec%0d.err", v), i, err_cnt[i], vecs[v].err);
        chk($sformatf("vec%0d.pass", v), i, pass[i], vecs[v].pass);
        chk($sformatf("vec%0d.logv", v), i, log_valid[i], vecs[v].err != 0);
        chk($sformatf("vec%0d.log_addr", v), i, log_addr[i], vecs[v].err != 0 ? vecs[v].addr : 10'h0);
        chk($sformatf("vec%0d.log_syn", v), i, log_syn[i], vecs[v].syn);
      end
    end

    // Six failures into a four-entry log.
    do_start("ovf");
    for (int k = 0; k < 6; k++) begin
      rd(10'h100 + 10'(k), 8'h00, 8'(k + 1), k == 5);
      if (k < 5) step();
    end
    wait_done("ovf");
    for (int i = 0; i < 3; i++) begin
      chk("ovf.err", i, err_cnt[i], 6);
      chk("ovf.flag", i, log_overflow[i], 1);
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ovf.pop%0d_v", k), i, log_valid[i], 1);
        chk($sformatf("ovf.pop%0d_addr", k), i, log_addr[i], 10'h100 + 10'(k));
        chk($sformatf("ovf.pop%0d_syn", k), i, log_syn[i], k + 1);
      end
      log_pop = '1; step(); log_pop = '0;
    end
    for (int i = 0; i < 3; i++) chk("ovf.empty", i, log_valid[i], 0);
    log_pop = '1; step(); log_pop = '0;
    for (int i = 0; i < 3; i++) begin
      chk("ovf.pop_empty_v", i, log_valid[i], 0);
      chk("ovf.pop_empty_addr", i, log_addr[i], 0);
    end

    // Pop on the exact cycle the fifth failure is pushed into a full log.
    do_start("pushpop");
    for (int k = 0; k < 5; k++) begin
      rd(10'h200 + 10'(k), 8'h00, 8'(k + 1), 1'b0);
      if (k < 4) step();
    end
    for (int n = 1; n <= 5; n++) begin
      step();
      if (n == 1) rd_en = 1'b0;
      for (int i = 0; i < 3; i++) log_pop[i] = (n == lat_of(i));
    end
    log_pop = '0;
    finish = 1'b1;
    wait_done("pushpop");
    for (int i = 0; i < 3; i++) begin
      chk("pushpop.err", i, err_cnt[i], 5);
      chk("pushpop.ovf", i, log_overflow[i], 0);
    end
    for (int k = 1; k < 5; k++) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("pushpop.pop%0d_addr", k), i, log_addr[i], 10'h200 + 10'(k));
        chk($sformatf("pushpop.pop%0d_syn", k), i, log_syn[i], k + 1);
      end
      log_pop = '1; step(); log_pop = '0;
    end
    for (int i = 0; i < 3; i++) chk("pushpop.empty", i, log_valid[i], 0);

    // Restart in DRAIN with a failing compare still in flight.
    do_start("drain");
    rd(10'h2AA, 8'h00, 8'hF0, 1'b1);
    step();
    rd_en = 1'b0; finish = 1'b0;
    for (int i = 0; i < 3; i++) chk("drain.in_drain", i, busy[i] && !done[i], 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain.restart_err", i, err_cnt[i], 0);
      chk("drain.restart_busy", i, busy[i], 1);
      chk("drain.restart_done", i, done[i], 0);
    end
    step(6);
    for (int i = 0; i < 3; i++) begin
      chk("drain.flushed_err", i, err_cnt[i], 0);
      chk("drain.flushed_logv", i, log_valid[i], 0);
    end

    // Reset in RUN with failures logged and more in flight.
    for (int k = 0; k < 3; k++) begin
      rd(10'h030 + 10'(k), 8'h0F, 8'h00, 1'b0);
      step();
    end
    rd_en = 1'b0;
    step(5);
    for (int i = 0; i < 3; i++) chk("rstrun.err_before", i, err_cnt[i], 3);
    rd(10'h040, 8'h0F, 8'h00, 1'b0); step();
    rd_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("rstrun");
    for (int k = 0; k < 3; k++) begin
      rd(10'h050 + 10'(k), 8'h0F, 8'h00, 1'b0);
      step();
    end
    rd_en = 1'b0;
    step(6);
    chk_zero("idle_ignore");

    // Saturation of the error counter.
    do_start("sat");
    for (int k = 0; k < 65534; k++) begin
      rd(10'(k), 8'h00, 8'h01, 1'b0);
      step();
    end
    rd_en = 1'b0;
    step(6);
    for (int i = 0; i < 3; i++) chk("sat.fffe", i, err_cnt[i], 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      rd(10'h3F0 + 10'(k), 8'h00, 8'h01, k == 2);
      if (k < 2) step();
    end
    wait_done("sat");
    for (int i = 0; i < 3; i++) begin
      chk("sat.ffff", i, err_cnt[i], 16'hFFFF);
      chk("sat.pass", i, pass[i], 0);
      chk("sat.ovf", i, log_overflow[i], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
